// File: rtl/cand_gen.sv
// cand_gen: enumerates lowercase candidates (length, then lexicographic), drives them into a hash core
// and compares the returned digest with a target. Define CAND_GEN_DIGITS_EN to append '0'..'9' to the charset.
module cand_gen #(
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] target_digest,
  output logic [255:0] data,
  output logic [63:0]  data_length,
  output logic         hash_start,
  input  logic [255:0] Hash_Digest,
  input  logic         hashing_done,
  input  logic         overflow_err,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         error,
  output logic [31:0]  attempts
);

  // IDLE: wait start | ISSUE: pulse hash_start | WAIT: await done | CHECK: compare/advance | FOUND/EXHAUSTED/ERROR: hold
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUSTED,
    S_ERROR
  } state_t;

`ifdef CAND_GEN_DIGITS_EN
  localparam logic [7:0] LAST_CH = 8'h39;

  function automatic logic [7:0] succ(input logic [7:0] c);
    return (c == 8'h7a) ? 8'h30 : c + 8'd1;
  endfunction
`else
  localparam logic [7:0] LAST_CH = 8'h7a;

  function automatic logic [7:0] succ(input logic [7:0] c);
    return c + 8'd1;
  endfunction
`endif

  state_t        state_q;
  logic [255:0]  data_q;
  logic [5:0]    len_q;
  logic          hash_start_q;
  logic          busy_q;
  logic          found_q;
  logic          exhausted_q;
  logic          error_q;
  logic [31:0]   attempts_q;
  logic          first_wait_q;
  logic          ovf_q;

  logic [255:0]  data_d;
  logic [5:0]    len_d;
  logic          wrap_d;
  logic          carry;

  // Odometer step: byte 0 is the rightmost character; a carry past the top grows the length.
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    carry  = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (carry) begin
        if (6'(i) < len_q) begin
          if (data_q[8*i +: 8] == LAST_CH) begin
            data_d[8*i +: 8] = 8'h61;
          end else begin
            data_d[8*i +: 8] = succ(data_q[8*i +: 8]);
            carry            = 1'b0;
          end
        end else begin
          data_d[8*i +: 8] = 8'h61;
          len_d            = len_q + 6'd1;
          carry            = 1'b0;
        end
      end
    end
    wrap_d = carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      len_q        <= '0;
      hash_start_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      error_q      <= 1'b0;
      attempts_q   <= '0;
      first_wait_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
          if (start) begin
            state_q      <= S_ISSUE;
            data_q       <= 256'h61;
            len_q        <= 6'd1;
            hash_start_q <= 1'b1;
            busy_q       <= 1'b1;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            error_q      <= 1'b0;
            attempts_q   <= '0;
          end
        end
        S_ISSUE: begin
          hash_start_q <= 1'b0;
          first_wait_q <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          first_wait_q <= 1'b0;
          if (!first_wait_q && hashing_done) begin
            ovf_q   <= overflow_err;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (attempts_q != 32'hFFFF_FFFF) begin
            attempts_q <= attempts_q + 32'd1;
          end
          if (ovf_q) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (Hash_Digest == target_digest) begin
            state_q <= S_FOUND;
            found_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (wrap_d) begin
            state_q     <= S_EXHAUSTED;
            exhausted_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            data_q       <= data_d;
            len_q        <= len_d;
            hash_start_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_length = {58'd0, len_q};
  assign hash_start  = hash_start_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign error       = error_q;
  assign attempts    = attempts_q;

endmodule

// File: tb/tb_cand_gen.sv
// Bench for cand_gen: two instances (MAX_LEN 8 and 2) each driven by a behavioural SHA-256 core,
// with a per-cycle monitor against an index-based model of the candidate enumeration.
module tb_cand_gen;

`ifdef CAND_GEN_DIGITS_EN
  localparam int N = 36;
`else
  localparam int N = 26;
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s   [2];
  logic         start_s [2];
  logic [255:0] tgt_s   [2];
  logic [255:0] data_s  [2];
  logic [63:0]  len_s   [2];
  logic         hs_s    [2];
  logic [255:0] dig_s   [2];
  logic         done_s  [2];
  logic         ovf_s   [2];
  logic         busy_s  [2];
  logic         found_s [2];
  logic         exh_s   [2];
  logic         err_s   [2];
  logic [31:0]  att_s   [2];
  int           hs_cnt  [2];
  int           ovf_at  [2];
  bit           rand_lat[2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single-block SHA-256 of a right-aligned message of len bytes (len <= 32).
  function automatic logic [255:0] sha256(input logic [255:0] d, input int len);
    logic [511:0] b;
    logic [31:0]  w [64];
    logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh, t1, t2, s0, s1;
    b = '0;
    for (int i = 0; i < len; i++) b[511-8*i -: 8] = d[8*(len-1-i) +: 8];
    b[511-8*len -: 8] = 8'h80;
    b[63:0] = 64'(len * 8);
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    va = H0[0]; vb = H0[1]; vc = H0[2]; vd = H0[3];
    ve = H0[4]; vf = H0[5]; vg = H0[6]; vh = H0[7];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25);
      t1 = vh + s1 + ((ve & vf) ^ (~ve & vg)) + K[i] + w[i];
      s0 = rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22);
      t2 = s0 + ((va & vb) ^ (va & vc) ^ (vb & vc));
      vh = vg; vg = vf; vf = ve; ve = vd + t1;
      vd = vc; vc = vb; vb = va; va = t1 + t2;
    end
    return {H0[0]+va, H0[1]+vb, H0[2]+vc, H0[3]+vd, H0[4]+ve, H0[5]+vf, H0[6]+vg, H0[7]+vh};
  endfunction

  function automatic logic [7:0] sym(input int v);
    return (v < 26) ? 8'(32'h61 + v) : 8'(32'h30 + v - 26);
  endfunction

  function automatic int dig(input logic [7:0] c);
    return (c >= 8'h61) ? int'(c) - 32'h61 : int'(c) - 32'h30 + 26;
  endfunction

  function automatic longint tot(input int ml);
    longint t = 0;
    longint p = 1;
    for (int l = 1; l <= ml; l++) begin
      p = p * N;
      t = t + p;
    end
    return t;
  endfunction

  // Candidate number idx (0-based) as {length, right-aligned bytes}: skip whole length classes, then base-N digits.
  function automatic logic [319:0] cand_of(input longint idx);
    longint       rem = idx;
    longint       p   = N;
    int           len = 1;
    logic [255:0] d   = '0;
    while (rem >= p && len < 40) begin
      rem = rem - p;
      p   = p * N;
      len++;
    end
    for (int i = 0; i < len && i < 32; i++) begin
      d[8*i +: 8] = sym(int'(rem % N));
      rem = rem / N;
    end
    return {64'(len), d};
  endfunction

  function automatic longint idx_of(input logic [255:0] d, input int len);
    longint v = 0;
    for (int i = len - 1; i >= 0; i--) v = v * N + dig(d[8*i +: 8]);
    return tot(len - 1) + v;
  endfunction

  function automatic logic [255:0] str_data(input string s);
    logic [255:0] d = '0;
    for (int i = 0; i < s.len(); i++) d = {d[247:0], s[i]};
    return d;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int ML = (g == 0) ? 8 : 2;

    cand_gen #(.MAX_LEN(ML)) dut (
      .clk          (clk),
      .reset        (rst_s[g]),
      .start        (start_s[g]),
      .target_digest(tgt_s[g]),
      .data         (data_s[g]),
      .data_length  (len_s[g]),
      .hash_start   (hs_s[g]),
      .Hash_Digest  (dig_s[g]),
      .hashing_done (done_s[g]),
      .overflow_err (ovf_s[g]),
      .busy         (busy_s[g]),
      .found        (found_s[g]),
      .exhausted    (exh_s[g]),
      .error        (err_s[g]),
      .attempts     (att_s[g])
    );

    logic [255:0] lat_d;
    logic [63:0]  lat_len;
    int           cnt;
    logic         this_ovf;

    // Hash core: latches on hash_start, drops done, raises done with the digest after the latency, holds it.
    always @(posedge clk) begin
      if (rst_s[g]) begin
        done_s[g] <= 1'b0;
        ovf_s[g]  <= 1'b0;
        dig_s[g]  <= '0;
        cnt       <= 0;
        hs_cnt[g] <= 0;
        this_ovf  <= 1'b0;
      end else if (hs_s[g]) begin
        lat_d     <= data_s[g];
        lat_len   <= len_s[g];
        done_s[g] <= 1'b0;
        ovf_s[g]  <= 1'b0;
        cnt       <= rand_lat[g] ? int'($urandom_range(4, 1)) : 5;
        hs_cnt[g] <= hs_cnt[g] + 1;
        this_ovf  <= (hs_cnt[g] + 1 == ovf_at[g]);
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          done_s[g] <= 1'b1;
          dig_s[g]  <= sha256(lat_d, int'(lat_len));
          ovf_s[g]  <= this_ovf;
        end
      end
    end

    longint issued    = 0;
    bit     armed     = 1'b0;
    bit     prev_rst  = 1'b0;
    bit     prev_busy = 1'b0;
    bit     prev_acc  = 1'b0;

    always @(negedge clk) begin
      if (prev_rst) begin
        armed  = 1'b1;
        issued = 0;
        chk("reset_vals", {hs_s[g], busy_s[g], found_s[g], exh_s[g], err_s[g], att_s[g], len_s[g], data_s[g]}, '0);
      end else if (armed) begin
        if (prev_acc)
          chk("issue_after_start", {hs_s[g], busy_s[g], found_s[g], exh_s[g], err_s[g], att_s[g]}, {2'b11, 35'd0});
        if (hs_s[g]) begin
          chk("hs_in_range", 400'(issued < tot(ML)), 400'd1);
          chk("cand", {len_s[g], data_s[g]}, cand_of(issued));
          issued++;
        end
        chk("attempts_track", att_s[g], busy_s[g] ? 32'(issued - 1) : 32'(issued));
        if (!busy_s[g]) chk("hs_while_idle", hs_s[g], 0);
        if (prev_busy && !busy_s[g]) begin
          chk("frozen", {len_s[g], data_s[g]}, cand_of(issued - 1));
          chk("one_flag", 400'($countones({found_s[g], exh_s[g], err_s[g]}) == 1), 400'd1);
        end
      end
      prev_acc = armed && !rst_s[g] && start_s[g] && !busy_s[g];
      if (prev_acc) issued = 0;
      prev_rst  = rst_s[g];
      prev_busy = busy_s[g];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int g, input logic [255:0] tgt, input logic [2:0] ef, input longint ea,
                     output logic [319:0] last);
    bit fin = 1'b0;
    tgt_s[g]   = tgt;
    start_s[g] = 1'b1;
    tick();
    start_s[g] = 1'b0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      tick();
      if (!busy_s[g]) fin = 1'b1;
    end
    chk("run_timeout", 400'(fin), 400'd1);
    chk("flags", {found_s[g], exh_s[g], err_s[g]}, ef);
    chk("attempts", att_s[g], 32'(ea));
    last = {len_s[g], data_s[g]};
    repeat (3) begin
      tick();
      chk("quiet", {hs_s[g], busy_s[g]}, 0);
    end
  endtask

  initial begin
    logic [319:0] last;
    logic [255:0] d;
    int           ln;
    int           base;
    bit           ok;
    for (int g = 0; g < 2; g++) begin
      rst_s[g] = 1'b1; start_s[g] = 1'b0; tgt_s[g] = '0; ovf_at[g] = 0; rand_lat[g] = 1'b0;
    end
    tick();
    tick();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    tick();

    chk("sha_abc", sha256(str_data("abc"), 3),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    chk("model_first_len2", cand_of(longint'(N)), {64'd2, 256'h6161});
`ifdef CAND_GEN_DIGITS_EN
    chk("model_tot2", 400'(tot(2)), 400'd1332);
`else
    chk("model_tot2", 400'(tot(2)), 400'd702);
`endif

    run(0, sha256(str_data("c"), 1), 3'b100, 3, last);
    chk("c_pw", last[319:0], {64'd1, 256'h63});

`ifdef CAND_GEN_DIGITS_EN
    run(0, sha256(str_data("abc"), 3), 3'b100, 1371, last);
`else
    run(0, sha256(str_data("abc"), 3), 3'b100, 731, last);
`endif
    chk("abc_pw", {last[319:256], last[23:0]}, {64'd3, 24'h616263});

`ifdef CAND_GEN_DIGITS_EN
    run(1, sha256(str_data("zzz"), 3), 3'b010, 1332, last);
    chk("exh_last", last, {64'd2, 256'h3939});
    run(1, sha256(str_data("0"), 1), 3'b100, 27, last);
    chk("after_z", last, {64'd1, 256'h30});
`else
    run(1, sha256(str_data("zzz"), 3), 3'b010, 702, last);
    chk("exh_last", last, {64'd2, 256'h7a7a});
`endif

    ovf_at[0] = hs_cnt[0] + 4;
    run(0, '1, 3'b001, 4, last);
    chk("err_last", last, {64'd1, 256'h64});
    ovf_at[0] = 0;

    // Reset mid-WAIT, with an ignored start pulse while busy beforehand.
    tgt_s[0]   = '1;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (3) tick();
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    base = hs_cnt[0];
    ok   = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      tick();
      if (hs_cnt[0] >= base + 2) ok = 1'b1;
    end
    chk("mid_wait_reached", 400'(ok), 400'd1);
    repeat (2) tick();
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    chk("rst_mid", {hs_s[0], busy_s[0], found_s[0], exh_s[0], err_s[0], att_s[0], len_s[0], data_s[0]}, '0);
    repeat (3) begin
      tick();
      chk("rst_quiet", {hs_s[0], busy_s[0]}, 0);
    end
    run(0, sha256(str_data("b"), 1), 3'b100, 2, last);
    chk("b_pw", last, {64'd1, 256'h62});

    // Randomized targets and core latencies.
    rand_lat[0] = 1'b1;
    rand_lat[1] = 1'b1;
    for (int r = 0; r < 5; r++) begin
      int g;
      g  = (r < 3) ? 1 : 0;
      ln = (g == 1) ? int'($urandom_range(3, 1)) : int'($urandom_range(2, 1));
      d  = '0;
      for (int i = 0; i < ln; i++) d = {d[247:0], sym(int'($urandom_range(N - 1, 0)))};
      if (g == 1 && ln > 2) begin
        run(g, sha256(d, ln), 3'b010, tot(2), last);
      end else begin
        run(g, sha256(d, ln), 3'b100, idx_of(d, ln) + 1, last);
        chk("rand_pw", last, {64'(ln), d});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
